// File: rtl/imem_byte_loader.sv
// Byte-stream instruction-memory loader: packs little-endian bytes into 32-bit
// words, drives the imem write port, and holds the core in reset until loaded.
module imem_byte_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  core_hold
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [1:0]  byte_idx;
    logic [31:0] asm_word;
    logic [31:0] next_word;
    logic        word_end;
    logic        full;

    assign byte_ready = (state == S_LOAD);
    assign word_end   = (byte_idx == 2'd3) || byte_last;
    // word_count only reaches its MSB at exactly DEPTH, so the MSB means "memory full"
    assign full       = word_count[ADDR_WIDTH];

    always_comb begin
        next_word = asm_word;
        case (byte_idx)
            2'd0:    next_word[7:0]   = byte_data;
            2'd1:    next_word[15:8]  = byte_data;
            2'd2:    next_word[23:16] = byte_data;
            default: next_word[31:24] = byte_data;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            byte_idx   <= 2'd0;
            asm_word   <= 32'd0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
            core_hold  <= 1'b1;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_LOAD;
                        byte_idx   <= 2'd0;
                        asm_word   <= 32'd0;
                        word_count <= '0;
                        overflow   <= 1'b0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        core_hold  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (byte_valid) begin
                        if (word_end) begin
                            // Clearing the assembly register leaves unfilled lanes of a short word at zero
                            asm_word <= 32'd0;
                            byte_idx <= 2'd0;
                            if (!full) begin
                                imem_we    <= 1'b1;
                                imem_waddr <= word_count[ADDR_WIDTH-1:0];
                                imem_wdata <= next_word;
                                word_count <= word_count + 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else begin
                            asm_word <= next_word;
                            byte_idx <= byte_idx + 2'd1;
                        end
                        if (byte_last) begin
                            state     <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_byte_loader.sv
// Scoreboard bench for imem_byte_loader: a default-depth instance and a 4-word
// instance share the byte stream; each is started by its own start pulse.
module tb_imem_byte_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'd0;
    logic       byte_last = 1'b0;

    logic       a_ready, a_we, a_busy, a_done, a_ovf, a_hold;
    logic [7:0] a_waddr;
    logic [31:0] a_wdata;
    logic [8:0] a_wc;
    logic       b_ready, b_we, b_busy, b_done, b_ovf, b_hold;
    logic [1:0] b_waddr;
    logic [31:0] b_wdata;
    logic [2:0] b_wc;

    int checks = 0;
    int failures = 0;
    bit sel_b = 1'b0;
    logic [7:0]  stim [$];
    logic [40:0] qa [$];
    logic [40:0] qb [$];

    logic       s_ready, s_we, s_busy, s_done, s_ovf, s_hold;
    logic [8:0] s_wc;

    always #5 clk = ~clk;

    imem_byte_loader #(.ADDR_WIDTH(8)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_last(byte_last), .byte_ready(a_ready),
        .imem_we(a_we), .imem_waddr(a_waddr), .imem_wdata(a_wdata), .busy(a_busy),
        .done(a_done), .overflow(a_ovf), .word_count(a_wc), .core_hold(a_hold)
    );

    imem_byte_loader #(.ADDR_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_last(byte_last), .byte_ready(b_ready),
        .imem_we(b_we), .imem_waddr(b_waddr), .imem_wdata(b_wdata), .busy(b_busy),
        .done(b_done), .overflow(b_ovf), .word_count(b_wc), .core_hold(b_hold)
    );

    always_comb begin
        s_ready = sel_b ? b_ready : a_ready;
        s_we    = sel_b ? b_we    : a_we;
        s_busy  = sel_b ? b_busy  : a_busy;
        s_done  = sel_b ? b_done  : a_done;
        s_ovf   = sel_b ? b_ovf   : a_ovf;
        s_hold  = sel_b ? b_hold  : a_hold;
        s_wc    = sel_b ? {6'd0, b_wc} : a_wc;
    end

    // Scoreboard entry: {final_word, addr[7:0], data[31:0]}
    always @(negedge clk) begin
        logic [40:0] e;
        if (a_we) begin
            checks++;
            if (qa.size() == 0) begin
                failures++;
                $display("FAIL a_unexpected_write addr=%h data=%h expected no write", a_waddr, a_wdata);
            end else begin
                e = qa.pop_front();
                if (a_waddr !== e[39:32] || a_wdata !== e[31:0] || a_wc !== {1'b0, e[39:32]} + 9'd1
                    || a_done !== e[40] || a_hold !== !e[40]) begin
                    failures++;
                    $display("FAIL a_write got addr=%h data=%h wc=%0d done=%b hold=%b expected addr=%h data=%h wc=%0d done=%b",
                             a_waddr, a_wdata, a_wc, a_done, a_hold, e[39:32], e[31:0], e[39:32] + 8'd1, e[40]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [40:0] e;
        if (b_we) begin
            checks++;
            if (qb.size() == 0) begin
                failures++;
                $display("FAIL b_unexpected_write addr=%h data=%h expected no write", b_waddr, b_wdata);
            end else begin
                e = qb.pop_front();
                if (b_waddr !== e[33:32] || b_wdata !== e[31:0] || b_wc !== {1'b0, e[33:32]} + 3'd1
                    || b_done !== e[40] || b_hold !== !e[40]) begin
                    failures++;
                    $display("FAIL b_write got addr=%h data=%h wc=%0d done=%b hold=%b expected addr=%h data=%h done=%b",
                             b_waddr, b_wdata, b_wc, b_done, b_hold, e[33:32], e[31:0], e[40]);
                end
            end
        end
    end

    task automatic push_exp(input bit sel, input logic [40:0] x);
        if (sel) qb.push_back(x);
        else qa.push_back(x);
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (a_ready !== 1'b0 || a_we !== 1'b0 || a_waddr !== 8'd0 || a_wdata !== 32'd0 || a_busy !== 1'b0
            || a_done !== 1'b0 || a_ovf !== 1'b0 || a_wc !== 9'd0 || a_hold !== 1'b1) begin
            failures++;
            $display("FAIL %s got rdy=%b we=%b addr=%h data=%h busy=%b done=%b ovf=%b wc=%0d hold=%b expected all 0 except hold=1",
                     tag, a_ready, a_we, a_waddr, a_wdata, a_busy, a_done, a_ovf, a_wc, a_hold);
        end
    endtask

    task automatic run_load(input bit sel, input bit gap, input int mid_start, input bit exp_ovf);
        int depth, cnt, lane, n;
        logic [31:0] acc;
        bit pend, fin;
        sel_b = sel;
        depth = sel ? 4 : 256;
        n = stim.size();
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        checks++;
        if (s_ready !== 1'b1 || s_busy !== 1'b1 || s_done !== 1'b0 || s_hold !== 1'b1 || s_wc !== 9'd0 || s_ovf !== 1'b0) begin
            failures++;
            $display("FAIL start_state got rdy=%b busy=%b done=%b hold=%b wc=%0d ovf=%b expected 1 1 0 1 0 0",
                     s_ready, s_busy, s_done, s_hold, s_wc, s_ovf);
        end
        cnt = 0; lane = 0; acc = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0) begin
                byte_valid = 1'b0; byte_last = 1'b0; byte_data = 8'hEE;
                @(negedge clk);
                checks++;
                if (s_we !== 1'b0) begin
                    failures++;
                    $display("FAIL bubble_we got %b expected 0", s_we);
                end
            end
            byte_valid = 1'b1; byte_data = stim[i]; byte_last = (i == n - 1);
            if (i == mid_start) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
            acc = acc | (32'(stim[i]) << (8 * lane));
            pend = 1'b0;
            fin = (i == n - 1);
            if (lane == 3 || fin) begin
                if (cnt < depth) begin
                    push_exp(sel, {fin, 8'(cnt), acc});
                    pend = 1'b1;
                    cnt++;
                end
                acc = 32'd0; lane = 0;
            end else begin
                lane++;
            end
            @(negedge clk);
            start_a = 1'b0; start_b = 1'b0;
            checks++;
            if (s_we !== pend) begin
                failures++;
                $display("FAIL write_latency byte=%0d got we=%b expected %b", i, s_we, pend);
            end
        end
        byte_valid = 1'b0; byte_last = 1'b0;
        checks++;
        if (s_done !== 1'b1 || s_hold !== 1'b0 || s_busy !== 1'b0 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL done_timing got done=%b hold=%b busy=%b rdy=%b expected 1 0 0 0", s_done, s_hold, s_busy, s_ready);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ((sel ? qb.size() : qa.size()) != 0) begin
            failures++;
            $display("FAIL missing_writes got %0d outstanding expected 0", sel ? qb.size() : qa.size());
        end
        checks++;
        if (s_wc !== 9'(cnt) || s_ovf !== exp_ovf || s_done !== 1'b1) begin
            failures++;
            $display("FAIL final_status got wc=%0d ovf=%b done=%b expected wc=%0d ovf=%b done=1", s_wc, s_ovf, s_done, cnt, exp_ovf);
        end
    endtask

    task automatic load_s1();
        stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset_values_a");
        checks++;
        if (b_ready !== 1'b0 || b_we !== 1'b0 || b_wc !== 3'd0 || b_hold !== 1'b1 || b_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_values_b got rdy=%b we=%b wc=%0d hold=%b done=%b", b_ready, b_we, b_wc, b_hold, b_done);
        end
        start_a = 1'b1;
        @(negedge clk);
        reset = 1'b0; start_a = 1'b0;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL start_during_reset got rdy=%b busy=%b expected 0 0", a_ready, a_busy);
        end
    endtask

    task automatic test_basic();
        load_s1();
        run_load(1'b0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_short_word();
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAB};
        run_load(1'b0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_bubbles();
        load_s1();
        run_load(1'b0, 1'b1, -1, 1'b0);
    endtask

    task automatic test_overflow();
        stim = {};
        for (int i = 0; i < 20; i++) stim.push_back(8'(i * 7 + 1));
        run_load(1'b1, 1'b0, -1, 1'b1);
        sel_b = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        load_s1();
        sel_b = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            byte_valid = 1'b1; byte_data = stim[i]; byte_last = 1'b0;
            if (i == 3) qa.push_back({1'b0, 8'd0, 32'h00000013});
            @(negedge clk);
            checks++;
            if (a_we !== (i == 3)) begin
                failures++;
                $display("FAIL pre_reset_write byte=%0d got we=%b expected %b", i, a_we, (i == 3));
            end
        end
        byte_valid = 1'b0;
        #1 reset = 1'b1;
        #1 check_reset_values("reset_mid_load");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("after_reset_release");
        checks++;
        if (qa.size() != 0) begin
            failures++;
            $display("FAIL reset_writes got %0d outstanding expected 0", qa.size());
        end
        run_load(1'b0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_start_ignored();
        load_s1();
        run_load(1'b0, 1'b0, 5, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_word();
        test_bubbles();
        test_overflow();
        test_reset_mid_load();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
